// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types for the memory-port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   arb_gnt_t   : requester identity used for grant / ownership
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_DCACHE = 1'b1
  } arb_gnt_t;

endpackage

// File: rtl/mem_arb_slot.sv
// mem_arb_slot -- one requester's pending slot.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   strobe/addr/wdata/rw  incoming request, latched when accepted
//   clear                 arbiter is in RESP for this slot (retire it)
//   capture, rdata_in     memory completion for this slot
//   pending               slot holds an unserved request
//   addr_q/wdata_q/rw_q   latched request
//   rdata_q               last captured read line (held between transactions)
module mem_arb_slot #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  strobe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rw,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic [DATA_WIDTH-1:0] wdata_q,
  output logic                  rw_q,
  output logic [DATA_WIDTH-1:0] rdata_q
);

  // A busy slot ignores strobes, except in its RESP cycle where the new
  // request replaces the retiring one (set wins over clear).
  logic accept;
  assign accept = strobe && (!pending || clear);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        addr_q  <= addr;
        wdata_q <= wdata;
        rw_q    <= rw;
      end else if (clear) begin
        pending <= 1'b0;
      end
      // Write completions carry no data; keep the previous read line.
      if (capture && !rw_q)
        rdata_q <= rdata_in;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one memory port between icache (read-only) and
// dcache (read/write). Each requester owns one pending slot; the FSM
// IDLE -> ISSUE -> WAIT -> RESP serves one transaction at a time.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   strobe/addr_icache_i                icache line-read request
//   rdata/done_icache_o                 icache response
//   strobe/addr/wdata/rw_dcache_i       dcache request (rw 1=write)
//   rdata/done_dcache_o                 dcache response
//   strobe/addr/wdata/rw_o              memory request (strobe one cycle)
//   rdata_i, done_i                     memory completion
// Config macro: MEM_ARB_RR_EN -- round-robin grant on simultaneous
// pending; when undefined dcache has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  strobe_icache_i,
  input  logic [ADDR_WIDTH-1:0] addr_icache_i,
  output logic [DATA_WIDTH-1:0] rdata_icache_o,
  output logic                  done_icache_o,
  input  logic                  strobe_dcache_i,
  input  logic [ADDR_WIDTH-1:0] addr_dcache_i,
  input  logic [DATA_WIDTH-1:0] wdata_dcache_i,
  input  logic                  rw_dcache_i,
  output logic [DATA_WIDTH-1:0] rdata_dcache_o,
  output logic                  done_dcache_o,
  output logic                  strobe_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  rw_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  done_i
);

  arb_state_t state, state_nxt;
  arb_gnt_t   owner, owner_nxt, gnt;
  logic       issue_load;

  logic                  ic_pend, dc_pend;
  logic [ADDR_WIDTH-1:0] ic_addr, dc_addr;
  logic [DATA_WIDTH-1:0] ic_wdata, dc_wdata;
  logic                  ic_rw, dc_rw;
  logic                  ic_cap, dc_cap, ic_clr, dc_clr;

  assign ic_cap = (state == WAIT) && done_i && (owner == GNT_ICACHE);
  assign dc_cap = (state == WAIT) && done_i && (owner == GNT_DCACHE);
  assign ic_clr = (state == RESP) && (owner == GNT_ICACHE);
  assign dc_clr = (state == RESP) && (owner == GNT_DCACHE);

  // icache is read-only: its slot carries a constant zero write line/rw.
  mem_arb_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ic_slot (
    .clk(clk), .rst_n(rst_n),
    .strobe(strobe_icache_i), .addr(addr_icache_i), .wdata('0), .rw(1'b0),
    .clear(ic_clr), .capture(ic_cap), .rdata_in(rdata_i),
    .pending(ic_pend), .addr_q(ic_addr), .wdata_q(ic_wdata), .rw_q(ic_rw),
    .rdata_q(rdata_icache_o)
  );

  mem_arb_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dc_slot (
    .clk(clk), .rst_n(rst_n),
    .strobe(strobe_dcache_i), .addr(addr_dcache_i), .wdata(wdata_dcache_i),
    .rw(rw_dcache_i),
    .clear(dc_clr), .capture(dc_cap), .rdata_in(rdata_i),
    .pending(dc_pend), .addr_q(dc_addr), .wdata_q(dc_wdata), .rw_q(dc_rw),
    .rdata_q(rdata_dcache_o)
  );

`ifdef MEM_ARB_RR_EN
  arb_gnt_t last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n)          last_grant <= GNT_ICACHE;
    else if (issue_load) last_grant <= gnt;
  end

  // On contention, favour whichever port was not served last.
  always_comb begin
    gnt = GNT_ICACHE;
    if (ic_pend && dc_pend)
      gnt = (last_grant == GNT_DCACHE) ? GNT_ICACHE : GNT_DCACHE;
    else if (dc_pend)
      gnt = GNT_DCACHE;
  end
`else
  always_comb begin
    gnt = GNT_ICACHE;
    if (dc_pend) gnt = GNT_DCACHE;
  end
`endif

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    issue_load = 1'b0;
    case (state)
      IDLE: if (ic_pend || dc_pend) begin
        owner_nxt  = gnt;
        issue_load = 1'b1;
        state_nxt  = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (done_i) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= GNT_ICACHE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Memory request and done pulses are registered one cycle ahead of the
  // state they belong to, so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_o      <= 1'b0;
      addr_o        <= '0;
      wdata_o       <= '0;
      rw_o          <= 1'b0;
      done_icache_o <= 1'b0;
      done_dcache_o <= 1'b0;
    end else begin
      strobe_o      <= issue_load;
      done_icache_o <= ic_cap;
      done_dcache_o <= dc_cap;
      if (issue_load) begin
        addr_o  <= (gnt == GNT_DCACHE) ? dc_addr  : ic_addr;
        wdata_o <= (gnt == GNT_DCACHE) ? dc_wdata : ic_wdata;
        rw_o    <= (gnt == GNT_DCACHE) ? dc_rw    : ic_rw;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          strobe_icache_i, strobe_dcache_i, rw_dcache_i, done_i;
  logic [AW-1:0] addr_icache_i, addr_dcache_i;
  logic [DW-1:0] wdata_dcache_i, rdata_i;
  logic [DW-1:0] rdata_icache_o, rdata_dcache_o, wdata_o;
  logic          done_icache_o, done_dcache_o, strobe_o, rw_o;
  logic [AW-1:0] addr_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .strobe_icache_i(strobe_icache_i), .addr_icache_i(addr_icache_i),
    .rdata_icache_o(rdata_icache_o), .done_icache_o(done_icache_o),
    .strobe_dcache_i(strobe_dcache_i), .addr_dcache_i(addr_dcache_i),
    .wdata_dcache_i(wdata_dcache_i), .rw_dcache_i(rw_dcache_i),
    .rdata_dcache_o(rdata_dcache_o), .done_dcache_o(done_dcache_o),
    .strobe_o(strobe_o), .addr_o(addr_o), .wdata_o(wdata_o), .rw_o(rw_o),
    .rdata_i(rdata_i), .done_i(done_i)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the memory request, records it, then completes it
  // with rd. Returns in the cycle where the owner's done pulse is visible.
  task automatic serve(input logic [DW-1:0] rd, output logic [AW-1:0] a,
                       output logic [DW-1:0] wd, output logic rw, output bit to);
    to = 1'b0;
    a  = '0;
    wd = '0;
    rw = 1'b0;
    for (int n = 0; n < 20 && strobe_o !== 1'b1; n++) tick();
    if (strobe_o !== 1'b1) begin
      to = 1'b1;
      return;
    end
    a  = addr_o;
    wd = wdata_o;
    rw = rw_o;
    tick(); tick(); tick();
    rdata_i = rd;
    done_i  = 1'b1;
    tick();
    done_i  = 1'b0;
    rdata_i = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks += 8;
    if (strobe_o !== 1'b0)      begin failures++; $display("FAIL reset_strobe got=%b exp=0", strobe_o); end
    if (rw_o !== 1'b0)          begin failures++; $display("FAIL reset_rw got=%b exp=0", rw_o); end
    if (addr_o !== '0)          begin failures++; $display("FAIL reset_addr got=%h exp=0", addr_o); end
    if (wdata_o !== '0)         begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
    if (done_icache_o !== 1'b0) begin failures++; $display("FAIL reset_done_ic got=%b exp=0", done_icache_o); end
    if (done_dcache_o !== 1'b0) begin failures++; $display("FAIL reset_done_dc got=%b exp=0", done_dcache_o); end
    if (rdata_icache_o !== '0)  begin failures++; $display("FAIL reset_rdata_ic got=%h exp=0", rdata_icache_o); end
    if (rdata_dcache_o !== '0)  begin failures++; $display("FAIL reset_rdata_dc got=%h exp=0", rdata_dcache_o); end
    rst_n = 1'b1;
    tick();
    // done_i while idle must be ignored
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    checks++;
    if ({done_icache_o, done_dcache_o, strobe_o} !== 3'b000) begin
      failures++; $display("FAIL idle_done_ignored got=%b exp=000", {done_icache_o, done_dcache_o, strobe_o});
    end
  endtask

  task automatic test_icache_read;
    logic [DW-1:0] rd;
    int extra;
    rd = {32{8'hA5}};
    strobe_icache_i = 1'b1;
    addr_icache_i   = 32'h8000_0040;
    tick();
    strobe_icache_i = 1'b0;
    addr_icache_i   = '0;
    checks++;
    if (strobe_o !== 1'b0) begin failures++; $display("FAIL ic_latency_early got=%b exp=0", strobe_o); end
    tick();
    checks += 3;
    if (strobe_o !== 1'b1)           begin failures++; $display("FAIL ic_strobe got=%b exp=1", strobe_o); end
    if (addr_o !== 32'h8000_0040)    begin failures++; $display("FAIL ic_addr got=%h exp=80000040", addr_o); end
    if (rw_o !== 1'b0)               begin failures++; $display("FAIL ic_rw got=%b exp=0", rw_o); end
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (strobe_o !== 1'b0 || done_icache_o !== 1'b0 || addr_o !== 32'h8000_0040) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL ic_wait_quiet got=%0d bad_cycles exp=0", extra); end
    rdata_i = rd;
    done_i  = 1'b1;
    tick();
    done_i  = 1'b0;
    rdata_i = '0;
    checks += 3;
    if (done_icache_o !== 1'b1) begin failures++; $display("FAIL ic_done got=%b exp=1", done_icache_o); end
    if (done_dcache_o !== 1'b0) begin failures++; $display("FAIL ic_done_dc got=%b exp=0", done_dcache_o); end
    if (rdata_icache_o !== rd)  begin failures++; $display("FAIL ic_rdata got=%h exp=%h", rdata_icache_o, rd); end
    tick();
    checks += 2;
    if (done_icache_o !== 1'b0) begin failures++; $display("FAIL ic_done_pulse got=%b exp=0", done_icache_o); end
    if (rdata_icache_o !== rd)  begin failures++; $display("FAIL ic_rdata_hold got=%h exp=%h", rdata_icache_o, rd); end
  endtask

  task automatic test_simultaneous;
    logic [AW-1:0] ga;
    logic [DW-1:0] gw, old_dc, wd, rd2;
    logic grw;
    bit to;
    wd  = {8{32'h1234_5678}};
    rd2 = {32{8'h5A}};
    old_dc = rdata_dcache_o;
    strobe_icache_i = 1'b1; addr_icache_i = 32'h8000_0000;
    strobe_dcache_i = 1'b1; addr_dcache_i = 32'h8000_1000;
    wdata_dcache_i  = wd;   rw_dcache_i   = 1'b1;
    tick();
    strobe_icache_i = 1'b0; strobe_dcache_i = 1'b0;
    serve({32{8'hEE}}, ga, gw, grw, to);
    checks += 7;
    if (to)                      begin failures++; $display("FAIL sim_first_timeout got=1 exp=0"); end
    if (ga !== 32'h8000_1000)    begin failures++; $display("FAIL sim_first_addr got=%h exp=80001000", ga); end
    if (grw !== 1'b1)            begin failures++; $display("FAIL sim_first_rw got=%b exp=1", grw); end
    if (gw !== wd)               begin failures++; $display("FAIL sim_first_wdata got=%h exp=%h", gw, wd); end
    if (done_dcache_o !== 1'b1)  begin failures++; $display("FAIL sim_first_done_dc got=%b exp=1", done_dcache_o); end
    if (done_icache_o !== 1'b0)  begin failures++; $display("FAIL sim_first_done_ic got=%b exp=0", done_icache_o); end
    if (rdata_dcache_o !== old_dc) begin failures++; $display("FAIL sim_write_rdata_hold got=%h exp=%h", rdata_dcache_o, old_dc); end
    serve(rd2, ga, gw, grw, to);
    checks += 6;
    if (to)                      begin failures++; $display("FAIL sim_second_timeout got=1 exp=0"); end
    if (ga !== 32'h8000_0000)    begin failures++; $display("FAIL sim_second_addr got=%h exp=80000000", ga); end
    if (grw !== 1'b0)            begin failures++; $display("FAIL sim_second_rw got=%b exp=0", grw); end
    if (done_icache_o !== 1'b1)  begin failures++; $display("FAIL sim_second_done_ic got=%b exp=1", done_icache_o); end
    if (done_dcache_o !== 1'b0)  begin failures++; $display("FAIL sim_second_done_dc got=%b exp=0", done_dcache_o); end
    if (rdata_icache_o !== rd2)  begin failures++; $display("FAIL sim_second_rdata got=%h exp=%h", rdata_icache_o, rd2); end
    tick();
    checks++;
    if ({done_icache_o, done_dcache_o, strobe_o} !== 3'b000) begin
      failures++; $display("FAIL sim_drained got=%b exp=000", {done_icache_o, done_dcache_o, strobe_o});
    end
  endtask

  task automatic test_resp_restrobe;
    logic [AW-1:0] ga;
    logic [DW-1:0] gw, rda, rdb;
    logic grw;
    bit to;
    rda = {8{32'hCAFE_0001}};
    rdb = {8{32'hCAFE_0002}};
    strobe_dcache_i = 1'b1; addr_dcache_i = 32'h8000_1100; rw_dcache_i = 1'b0;
    tick();
    strobe_dcache_i = 1'b0;
    serve(rda, ga, gw, grw, to);
    checks += 4;
    if (to)                      begin failures++; $display("FAIL rs_first_timeout got=1 exp=0"); end
    if (ga !== 32'h8000_1100)    begin failures++; $display("FAIL rs_first_addr got=%h exp=80001100", ga); end
    if (done_dcache_o !== 1'b1)  begin failures++; $display("FAIL rs_first_done got=%b exp=1", done_dcache_o); end
    if (rdata_dcache_o !== rda)  begin failures++; $display("FAIL rs_first_rdata got=%h exp=%h", rdata_dcache_o, rda); end
    // new request lands in the RESP cycle of the previous one
    strobe_dcache_i = 1'b1; addr_dcache_i = 32'h8000_2000; rw_dcache_i = 1'b0;
    tick();
    strobe_dcache_i = 1'b0;
    checks++;
    if (done_dcache_o !== 1'b0)  begin failures++; $display("FAIL rs_done_pulse got=%b exp=0", done_dcache_o); end
    serve(rdb, ga, gw, grw, to);
    checks += 4;
    if (to)                      begin failures++; $display("FAIL rs_second_timeout got=1 exp=0"); end
    if (ga !== 32'h8000_2000)    begin failures++; $display("FAIL rs_second_addr got=%h exp=80002000", ga); end
    if (done_dcache_o !== 1'b1)  begin failures++; $display("FAIL rs_second_done got=%b exp=1", done_dcache_o); end
    if (rdata_dcache_o !== rdb)  begin failures++; $display("FAIL rs_second_rdata got=%h exp=%h", rdata_dcache_o, rdb); end
    tick();
  endtask

  task automatic test_grant_order;
    logic exp_rw [4];
    logic [AW-1:0] ga;
    logic [DW-1:0] gw;
    logic grw;
    bit to;
`ifdef MEM_ARB_RR_EN
    exp_rw = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_rw = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    strobe_icache_i = 1'b1; addr_icache_i = 32'h8000_0100;
    strobe_dcache_i = 1'b1; addr_dcache_i = 32'h8000_0200;
    rw_dcache_i = 1'b1; wdata_dcache_i = {8{32'h0BAD_F00D}};
    tick();
    strobe_icache_i = 1'b0; strobe_dcache_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      serve({32{8'h11}}, ga, gw, grw, to);
      checks += 3;
      if (to)                        begin failures++; $display("FAIL go_timeout_%0d got=1 exp=0", k); end
      if (grw !== exp_rw[k])         begin failures++; $display("FAIL go_grant_%0d got_rw=%b exp_rw=%b", k, grw, exp_rw[k]); end
      if (done_dcache_o !== exp_rw[k]) begin failures++; $display("FAIL go_done_dc_%0d got=%b exp=%b", k, done_dcache_o, exp_rw[k]); end
      strobe_icache_i = 1'b1; strobe_dcache_i = 1'b1;
      tick();
      strobe_icache_i = 1'b0; strobe_dcache_i = 1'b0;
    end
    // drain whatever is still pending
    for (int k = 0; k < 2; k++) begin
      serve({32{8'h22}}, ga, gw, grw, to);
      checks++;
      if (to) begin failures++; $display("FAIL go_drain_timeout_%0d got=1 exp=0", k); end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    logic [AW-1:0] ga;
    logic [DW-1:0] gw, rd;
    logic grw;
    bit to;
    int bad;
    rd = {32{8'h3C}};
    strobe_dcache_i = 1'b1; addr_dcache_i = 32'h8000_4000;
    wdata_dcache_i  = {8{32'hDEAD_BEEF}}; rw_dcache_i = 1'b1;
    tick();
    strobe_dcache_i = 1'b0;
    tick();
    checks++;
    if (strobe_o !== 1'b1) begin failures++; $display("FAIL rm_issue got=%b exp=1", strobe_o); end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks += 6;
    if (strobe_o !== 1'b0)     begin failures++; $display("FAIL rm_strobe got=%b exp=0", strobe_o); end
    if (rw_o !== 1'b0)         begin failures++; $display("FAIL rm_rw got=%b exp=0", rw_o); end
    if (addr_o !== '0)         begin failures++; $display("FAIL rm_addr got=%h exp=0", addr_o); end
    if (wdata_o !== '0)        begin failures++; $display("FAIL rm_wdata got=%h exp=0", wdata_o); end
    if (rdata_icache_o !== '0) begin failures++; $display("FAIL rm_rdata_ic got=%h exp=0", rdata_icache_o); end
    if (rdata_dcache_o !== '0) begin failures++; $display("FAIL rm_rdata_dc got=%h exp=0", rdata_dcache_o); end
    done_i = 1'b1; rdata_i = {DW{1'b1}};
    tick();
    done_i = 1'b0; rdata_i = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_icache_o !== 1'b0 || done_dcache_o !== 1'b0 || strobe_o !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rm_late_done got=%0d bad_cycles exp=0", bad); end
    strobe_dcache_i = 1'b1; addr_dcache_i = 32'h8000_3000; rw_dcache_i = 1'b0;
    tick();
    strobe_dcache_i = 1'b0;
    serve(rd, ga, gw, grw, to);
    checks += 4;
    if (to)                     begin failures++; $display("FAIL rm_after_timeout got=1 exp=0"); end
    if (ga !== 32'h8000_3000)   begin failures++; $display("FAIL rm_after_addr got=%h exp=80003000", ga); end
    if (done_dcache_o !== 1'b1) begin failures++; $display("FAIL rm_after_done got=%b exp=1", done_dcache_o); end
    if (rdata_dcache_o !== rd)  begin failures++; $display("FAIL rm_after_rdata got=%h exp=%h", rdata_dcache_o, rd); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    strobe_icache_i = 1'b0; addr_icache_i = '0;
    strobe_dcache_i = 1'b0; addr_dcache_i = '0;
    wdata_dcache_i = '0; rw_dcache_i = 1'b0;
    rdata_i = '0; done_i = 1'b0;
    test_reset();
    test_icache_read();
    test_simultaneous();
    test_resp_restrobe();
    test_grant_order();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 256, cache-line width on all data ports.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 strobe_icache_i  input  1  icache line-read request pulse.
REQ-006 addr_icache_i  input  ADDR_WIDTH  icache line address, valid with strobe.
REQ-007 rdata_icache_o  output  DATA_WIDTH  icache line data, valid while done_icache_o high.
REQ-008 done_icache_o  output  1  icache completion pulse.
REQ-009 strobe_dcache_i  input  1  dcache request pulse.
REQ-010 addr_dcache_i / wdata_dcache_i / rw_dcache_i  input  ADDR_WIDTH / DATA_WIDTH / 1  dcache address, write line, 1=write 0=read; valid with strobe.
REQ-011 rdata_dcache_o  output  DATA_WIDTH  dcache read line, valid while done_dcache_o high.
REQ-012 done_dcache_o  output  1  dcache completion pulse.
REQ-013 strobe_o / addr_o / wdata_o / rw_o  output  1 / ADDR_WIDTH / DATA_WIDTH / 1  single memory-port request.
REQ-014 rdata_i / done_i  input  DATA_WIDTH / 1  memory read data and completion pulse (rdata_i valid when done_i high).

Function
REQ-015 Each requester port SHALL own one pending slot; strobe high sets pending and latches addr (and wdata, rw for dcache) that cycle.
REQ-016 Strobe on a port whose slot is already pending and not in RESP SHALL be ignored (no relatch).
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; encoding from shared package.
REQ-018 IDLE: no pending -> stay; any pending -> select grant, register owner, go ISSUE.
REQ-019 ISSUE: strobe_o=1 for exactly one cycle with owner's latched addr/wdata/rw (rw_o=0 for icache) -> WAIT.
REQ-020 WAIT: strobe_o=0; addr_o/wdata_o/rw_o held; on done_i capture rdata_i into owner's rdata register -> RESP; done_i in IDLE/ISSUE/RESP ignored.
REQ-021 RESP: owner's done_*_o=1 for exactly one cycle, owner slot cleared -> IDLE; other port's done stays 0.
REQ-022 Strobe on the owner port during RESP SHALL set pending again (set wins over clear) and latch new request.
REQ-023 Strobe on the non-owner port at any time SHALL be captured per REQ-015 and served after current transaction.
REQ-024 Latency, no contention: strobe cycle T -> strobe_o at T+2 -> done_i at cycle D -> done_*_o at D+1.
REQ-025 rdata_*_o SHALL hold last captured value between transactions; dcache write completion leaves rdata_dcache_o unchanged.
REQ-026 All outputs registered; no combinational input-to-output path.
REQ-027 Grant without MEM_ARB_RR_EN: dcache wins simultaneous pending.

Reset
REQ-028 rst_n low SHALL force IDLE, clear both slots and owner, last_grant=icache, all outputs 0 (strobe_o, rw_o, done_*, addr_o, wdata_o, rdata_*).
REQ-029 Reset mid-transaction SHALL abandon it silently: no done_*_o pulse; late done_i after reset ignored.

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous pending grant the port not granted last; last_grant updated in IDLE->ISSUE.
REQ-031 Macro MEM_ARB_RR_EN undefined: fixed dcache priority, last_grant logic absent.

Structure
REQ-032 Package mem_arb_pkg SHALL hold state enum (IDLE, ISSUE, WAIT, RESP) and grant enum (GNT_ICACHE, GNT_DCACHE).
REQ-033 Sub-module mem_arb_slot SHALL implement one pending slot (pending flag, latched request, rdata register), instantiated twice.

Verification
REQ-034 icache read 0x80000040 alone, memory done_i after 17 cycles with rdata 0xA5.. -> strobe_o once, addr_o=0x80000040, rw_o=0, done_icache_o one cycle after done_i, rdata_icache_o=0xA5...
REQ-035 Simultaneous icache read 0x80000000 and dcache write 0x80001000 -> dcache issued first (rw_o=1), then icache; each done pulses once, in order.
REQ-036 MEM_ARB_RR_EN, both ports strobe every completion for 4 transactions -> grants D,I,D,I.
REQ-037 dcache strobes again during its RESP cycle with addr 0x80002000 -> second transaction issued, addr_o=0x80002000, no lost request.
REQ-038 rst_n low during WAIT, then done_i pulse -> no done_*_o, all outputs 0, next strobe served normally.
